// File: rtl/irq_dispatch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | irq_dispatch_pkg                                                           |
// | Shared types and helpers for the multi-core interrupt dispatcher.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package irq_dispatch_pkg;

  localparam int MAX_SRC = 256;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OFFER  = 2'd1,
    RETIRE = 2'd2
  } core_state_e;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Returns 0 for an all-zero vector; callers qualify with a reduction OR.
  function automatic int unsigned lowest_set(input logic [MAX_SRC-1:0] v);
    int unsigned r;
    r = 0;
    for (int i = MAX_SRC - 1; i >= 0; i--) begin
      if (v[i]) r = i;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/irq_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | irq_rr_arbiter                                                             |
// | One-hot grant to the first request at or after the pointer, wrapping.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module irq_rr_arbiter #(
  parameter  int N     = 4,
  localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt,
  output logic             o_vld
);

  logic [PTR_W-1:0] w_idx;

  // Walk offsets from farthest to nearest so the nearest request wins.
  always_comb begin
    o_gnt = '0;
    w_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      w_idx = PTR_W'((int'(i_ptr) + i) % N);
      if (i_req[w_idx]) begin
        o_gnt        = '0;
        o_gnt[w_idx] = 1'b1;
      end
    end
  end

  assign o_vld = |i_req;

endmodule
`default_nettype wire

// File: rtl/irq_dispatch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | irq_dispatch_ctrl                                                          |
// | Offers pending sources to idle cores round-robin and retires them on ack.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module irq_dispatch_ctrl
  import irq_dispatch_pkg::*;
#(
  parameter  int N_CORES = 4,
  parameter  int N_SRC   = 32,
  parameter  int TIMEOUT = 255,
  localparam int ID_W    = id_width(N_SRC)
) (
  input  logic                    HCLK,
  input  logic                    HRESET,
  input  logic [N_SRC-1:0]        pending_i,
  input  logic [N_CORES-1:0]      core_en_i,
  output logic [N_CORES-1:0]      core_irq_o,
  output logic [N_CORES*ID_W-1:0] core_id_o,
  input  logic [N_CORES-1:0]      core_ack_i,
  output logic [N_SRC-1:0]        clear_o,
  output logic [N_CORES-1:0]      timeout_o
);

  localparam int PTR_W = id_width(N_CORES);
  localparam int CNT_W = id_width(TIMEOUT + 1);

  core_state_e      r_state [N_CORES];
  logic [ID_W-1:0]  r_id    [N_CORES];
  logic [CNT_W-1:0] r_cnt   [N_CORES];
  logic [PTR_W-1:0] r_ptr;
  logic [N_SRC-1:0] r_clear;
  logic [N_CORES-1:0] r_tmo;

  logic [N_SRC-1:0]   w_inflight;
  logic [N_SRC-1:0]   w_elig;
  logic [ID_W-1:0]    w_src;
  logic [N_CORES-1:0] w_free;
  logic [N_CORES-1:0] w_gnt;
  logic               w_gnt_vld;
  logic               w_assign;
  logic [PTR_W-1:0]   w_gnt_idx;
  logic [PTR_W-1:0]   w_ptr_nxt;
  logic [N_CORES-1:0] w_tmo;

  // A source stays in flight through RETIRE to mask the stale pending bit.
  always_comb begin
    w_inflight = '0;
    w_free     = '0;
    w_tmo      = '0;
    for (int k = 0; k < N_CORES; k++) begin
      if (r_state[k] != IDLE) w_inflight[r_id[k]] = 1'b1;
      w_free[k] = (r_state[k] == IDLE) && core_en_i[k];
      w_tmo[k]  = (TIMEOUT != 0) && (r_state[k] == OFFER) &&
                  (int'(r_cnt[k]) == TIMEOUT - 1);
    end
  end

  assign w_elig    = pending_i & ~w_inflight;
  assign w_src     = ID_W'(lowest_set(MAX_SRC'(w_elig)));
  assign w_assign  = (|w_elig) && w_gnt_vld;
  assign w_gnt_idx = PTR_W'(lowest_set(MAX_SRC'(w_gnt)));
  assign w_ptr_nxt = (int'(w_gnt_idx) == N_CORES - 1) ? '0 : w_gnt_idx + 1'b1;

  irq_rr_arbiter #(.N(N_CORES)) u_core_arb (
    .i_req (w_free),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_vld (w_gnt_vld)
  );

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_ptr   <= '0;
      r_clear <= '0;
      r_tmo   <= '0;
      for (int k = 0; k < N_CORES; k++) begin
        r_state[k] <= IDLE;
        r_id[k]    <= '0;
        r_cnt[k]   <= '0;
      end
    end else begin
      r_clear <= '0;
      r_tmo   <= '0;
      if (w_assign) r_ptr <= w_ptr_nxt;
      for (int k = 0; k < N_CORES; k++) begin
        case (r_state[k])
          IDLE: begin
            if (w_assign && w_gnt[k]) begin
              r_state[k] <= OFFER;
              r_id[k]    <= w_src;
              r_cnt[k]   <= '0;
            end
          end
          OFFER: begin
            if (core_ack_i[k]) begin
              r_state[k]       <= RETIRE;
              r_cnt[k]         <= '0;
              r_clear[r_id[k]] <= 1'b1;
            end else if (w_tmo[k] || !pending_i[r_id[k]] || !core_en_i[k]) begin
              r_state[k] <= IDLE;
              r_tmo[k]   <= w_tmo[k];
            end else begin
              r_cnt[k] <= r_cnt[k] + 1'b1;
            end
          end
          RETIRE: begin
            if (r_cnt[k] == CNT_W'(1)) r_state[k] <= IDLE;
            else                       r_cnt[k]   <= r_cnt[k] + 1'b1;
          end
          default: r_state[k] <= IDLE;
        endcase
      end
    end
  end

  generate
    for (genvar k = 0; k < N_CORES; k++) begin : g_out
      assign core_irq_o[k]               = (r_state[k] == OFFER);
      assign core_id_o[k*ID_W +: ID_W]   = r_id[k];
    end
  endgenerate

  assign clear_o   = r_clear;
  assign timeout_o = r_tmo;

endmodule
`default_nettype wire

// File: tb/tb_irq_dispatch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_irq_dispatch_ctrl                                                       |
// | Directed and random stimulus against a cycle-level dispatch model.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_irq_dispatch_ctrl;

  localparam int NC  = 4;
  localparam int NS  = 32;
  localparam int TMO = 8;
  localparam int IW  = 5;

  logic          HCLK = 1'b0;
  logic          HRESET;
  logic [NS-1:0] pending_i;
  logic [NC-1:0] core_en_i;
  logic [NC-1:0] core_ack_i;
  logic [NC-1:0] core_irq_o;
  logic [NC*IW-1:0] core_id_o;
  logic [NS-1:0] clear_o;
  logic [NC-1:0] timeout_o;

  always #5 HCLK = ~HCLK;

  irq_dispatch_ctrl #(.N_CORES(NC), .N_SRC(NS), .TIMEOUT(TMO)) dut (
    .HCLK       (HCLK),
    .HRESET     (HRESET),
    .pending_i  (pending_i),
    .core_en_i  (core_en_i),
    .core_irq_o (core_irq_o),
    .core_id_o  (core_id_o),
    .core_ack_i (core_ack_i),
    .clear_o    (clear_o),
    .timeout_o  (timeout_o)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: mode 0 = free, 1 = offering, 2 = retiring; times in absolute cycles.
  int m_mode  [NC];
  int m_id    [NC];
  int m_start [NC];
  int m_rel   [NC];
  int m_ptr;
  int cyc = 0;
  logic [NS-1:0] m_clear;
  logic [NC-1:0] m_tmo;
  logic [NS-1:0] sh1 = '0, sh2 = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NC; k++) begin
      m_mode[k] = 0; m_id[k] = 0; m_start[k] = 0; m_rel[k] = 0;
    end
    m_ptr = 0; m_clear = '0; m_tmo = '0;
    cyc++;
  endtask

  task automatic model_step();
    int nmode[NC]; int nid[NC]; int nstart[NC]; int nrel[NC];
    logic [NS-1:0] infl;
    int src, core, c;
    nmode = m_mode; nid = m_id; nstart = m_start; nrel = m_rel;
    infl = '0; m_clear = '0; m_tmo = '0;
    for (int k = 0; k < NC; k++) if (m_mode[k] != 0) infl[m_id[k]] = 1'b1;
    for (int k = 0; k < NC; k++) begin
      if (m_mode[k] == 1) begin
        bit to;
        to = (TMO != 0) && (cyc - m_start[k] + 1 == TMO);
        if (core_ack_i[k]) begin
          nmode[k] = 2; nrel[k] = cyc + 3; m_clear[m_id[k]] = 1'b1;
        end else if (to || !pending_i[m_id[k]] || !core_en_i[k]) begin
          nmode[k] = 0; m_tmo[k] = to;
        end
      end else if (m_mode[k] == 2 && cyc + 1 == m_rel[k]) begin
        nmode[k] = 0;
      end
    end
    src = -1;
    for (int i = NS - 1; i >= 0; i--) if (pending_i[i] && !infl[i]) src = i;
    core = -1;
    for (int j = 0; j < NC; j++) begin
      c = (m_ptr + j) % NC;
      if (core < 0 && m_mode[c] == 0 && core_en_i[c]) core = c;
    end
    if (src >= 0 && core >= 0) begin
      nmode[core] = 1; nid[core] = src; nstart[core] = cyc + 1;
      m_ptr = (core + 1) % NC;
    end
    m_mode = nmode; m_id = nid; m_start = nstart; m_rel = nrel;
    cyc++;
  endtask

  task automatic compare_all();
    logic [NC-1:0] ei;
    logic [NC*IW-1:0] eid, gid;
    ei = '0; eid = '0; gid = '0;
    for (int k = 0; k < NC; k++) begin
      ei[k] = (m_mode[k] == 1);
      if (ei[k]) begin
        eid[k*IW +: IW] = IW'(m_id[k]);
        gid[k*IW +: IW] = core_id_o[k*IW +: IW];
      end
    end
    check("core_irq", 64'(core_irq_o), 64'(ei));
    check("core_id", 64'(gid), 64'(eid));
    check("clear", 64'(clear_o), 64'(m_clear));
    check("timeout", 64'(timeout_o), 64'(m_tmo));
  endtask

  // One clock: advance the model, sample the DUT, then emulate the service
  // unit dropping each cleared pending bit two cycles after its pulse.
  task automatic step();
    if (HRESET) model_reset(); else model_step();
    @(posedge HCLK); #1;
    compare_all();
    pending_i = pending_i & ~sh2;
    sh2 = sh1;
    sh1 = clear_o;
  endtask

  task automatic do_reset();
    HRESET = 1'b1;
    step();
    HRESET = 1'b0;
  endtask

  initial begin
    HRESET = 1'b1; pending_i = '0; core_en_i = '1; core_ack_i = '0;
    step();
    step();
    check("rst_id", 64'(core_id_o), 64'd0);
    HRESET = 1'b0;

    // single source, ack after three cycles
    pending_i = 32'h10;
    step();
    check("t1_irq", 64'(core_irq_o), 64'h1);
    check("t1_id", 64'(core_id_o[IW-1:0]), 64'd4);
    step(); step();
    core_ack_i = 4'b0001;
    step();
    core_ack_i = '0;
    check("t1_clr", 64'(clear_o), 64'h10);
    for (int i = 0; i < 3; i++) step();
    check("t1_idle", 64'(core_irq_o), 64'h0);

    // round robin over three sources
    do_reset();
    pending_i = 32'h7;
    step(); check("rr0", 64'(core_irq_o), 64'h1);
    step(); check("rr1", 64'(core_irq_o), 64'h3);
    step(); check("rr2", 64'(core_irq_o), 64'h7);
    check("rr_ids", 64'(core_id_o[3*IW-1:0]), 64'({5'd2, 5'd1, 5'd0}));
    step(); step();

    // timeout and reoffer to the next core
    do_reset();
    pending_i = 32'h1;
    step();
    for (int i = 0; i < TMO - 1; i++) step();
    check("tmo_irq_hi", 64'(core_irq_o), 64'h1);
    step();
    check("tmo_irq", 64'(core_irq_o), 64'h0);
    check("tmo_pulse", 64'(timeout_o), 64'h1);
    step();
    check("tmo_reoffer", 64'(core_irq_o), 64'h2);

    // withdraw by pending drop plus disable, then ack beating both
    do_reset();
    pending_i = 32'h20;
    step();
    pending_i = '0; core_en_i = 4'b1110;
    step();
    check("wd_irq", 64'(core_irq_o), 64'h0);
    check("wd_clr", 64'(clear_o), 64'h0);
    pending_i = 32'h20; core_en_i = '1;
    step();
    check("wd_reoffer", 64'(core_irq_o), 64'h2);
    pending_i = '0; core_en_i = 4'b1101; core_ack_i = 4'b0010;
    step();
    core_ack_i = '0; core_en_i = '1;
    check("ack_clr", 64'(clear_o), 64'h20);
    step(); step(); step();

    // disabled cores are skipped
    do_reset();
    core_en_i = 4'b1010; pending_i = 32'h3;
    step(); step();
    check("dis_irq", 64'(core_irq_o), 64'ha);
    pending_i = '0; core_en_i = '1;
    step();

    // reset with two offers outstanding
    do_reset();
    pending_i = 32'h3;
    step(); step();
    check("mid_two", 64'(core_irq_o), 64'h3);
    HRESET = 1'b1;
    step();
    check("mid_rst_id", 64'(core_id_o), 64'd0);
    HRESET = 1'b0;
    step();
    check("mid_reoffer", 64'(core_irq_o), 64'h1);

    // random traffic
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 3) == 0) pending_i[$urandom_range(0, NS-1)] = 1'b1;
      if ($urandom_range(0, 31) == 0) pending_i[$urandom_range(0, NS-1)] = 1'b0;
      for (int k = 0; k < NC; k++) begin
        core_en_i[k]  = ($urandom_range(0, 15) != 0);
        core_ack_i[k] = ($urandom_range(0, 3) == 0);
      end
      HRESET = ($urandom_range(0, 499) == 0);
      step();
    end
    HRESET = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/irq_dispatch_ctrl.md
Name: irq_dispatch_ctrl

Overview:
- Multi-core interrupt dispatcher between the APB event/service unit's pending vector and N cluster cores.
- Picks the lowest-index pending source not already in flight and offers it to an idle, enabled core, chosen round-robin.
- Waits for that core's acknowledge, then pulses a per-source clear back to the service unit's clear-pending path.
- Releases offers that time out, lose their source, or whose core is disabled.

Parameters:
- N_CORES, 4, number of cores served.
- N_SRC, 32, number of interrupt/event sources.
- TIMEOUT, 255, cycles an offer may stay unacknowledged before withdrawal; 0 disables the timeout.
- ID_W, derived $clog2(N_SRC), width of a source id; localparam, not overridable.

Ports:
- HCLK  in  1  clock.
- HRESET  in  1  synchronous active-high reset.
- pending_i  in  N_SRC  level pending vector from the service unit.
- core_en_i  in  N_CORES  core accepts interrupts.
- core_irq_o  out  N_CORES  offer valid, per core.
- core_id_o  out  N_CORES*ID_W  offered source id, per core; core k occupies bits [k*ID_W +: ID_W].
- core_ack_i  in  N_CORES  core takes the offered id.
- clear_o  out  N_SRC  one-cycle clear pulse per source.
- timeout_o  out  N_CORES  one-cycle pulse when an offer is withdrawn by timeout.

Behaviour:
- Reset (HCLK edge with HRESET=1):
  - all cores IDLE; core_irq_o, core_id_o, clear_o and timeout_o are 0.
  - in-flight mask 0, round-robin pointer 0, timeout counters 0.
  - A reset mid-offer drops the offer with no clear pulse.
- Per-core FSM:
  - IDLE -> OFFER on assignment.
  - OFFER -> RETIRE on ack.
  - OFFER -> IDLE on withdraw.
  - RETIRE -> IDLE after 2 cycles.
- Assignment, evaluated every cycle:
  - eligible = pending_i & ~inflight.
  - src = lowest set index of eligible.
  - core = first core at or after rr_ptr (wrapping modulo N_CORES) that is IDLE with core_en_i=1.
  - At most one assignment per cycle. If no eligible source or no free core, nothing happens.
- Assignment timing, for an assignment decided in cycle t:
  - at t+1: state=OFFER, core_irq_o=1, core_id_o=src, inflight[src]=1, rr_ptr=core+1 (modulo N_CORES).
  - core_id_o is held stable for the whole OFFER.
- Ack sampled in OFFER at cycle t:
  - at t+1: core_irq_o=0, clear_o[id]=1 for exactly one cycle, state=RETIRE.
  - inflight[id] stays set through RETIRE so the stale pending bit (cleared by the service unit two cycles after the pulse) is not redispatched.
  - at t+3: state=IDLE, inflight[id]=0.
- Withdraw from OFFER, evaluated at cycle t, takes effect at t+1: core_irq_o=0, inflight released, no clear_o pulse. Causes:
  - pending_i[id]=0 (software cleared the source);
  - core_en_i=0;
  - timeout counter reaches TIMEOUT with TIMEOUT≠0; the counter starts at 0 on entering OFFER. A timeout withdraw also pulses timeout_o[core]=1 at t+1.
- Priority of simultaneous events: ack beats every withdraw cause. A core that is freed at t cannot be reassigned before t+1.
- Acks in IDLE or RETIRE are ignored.
- clear_o may carry several bits in one cycle, one per core retiring.
- The withdrawn/released source is eligible again in the cycle after release.

Decomposition:
- irq_dispatch_pkg holds:
  - state enum: IDLE, OFFER, RETIRE;
  - id-width function;
  - lowest-set-index priority encoder function.
- One sub-module, irq_rr_arbiter: N-way round-robin grant over a request vector, with pointer input and one-hot grant output. It is reused for core selection.

Test Plan:
- Single source: pending_i=0x10, all cores enabled, ack core0 after 3 cycles -> core_irq_o[0]=1 with id=4 one cycle after pending; clear_o=0x10 pulses one cycle after ack; core0 IDLE 3 cycles after ack.
- Round-robin: pending_i=0x7 with no acks -> ids 0, 1, 2 offered to cores 0, 1, 2 on consecutive cycles; no source is offered twice.
- Timeout: TIMEOUT=8, pending_i=0x1, never ack -> core_irq_o[0] drops and timeout_o[0] pulses 8 cycles after the offer; no clear_o; source 0 is reoffered to core1.
- Withdraw: during OFFER of id 5, deassert pending_i[5] in the same cycle that core_en_i[k] falls -> offer dropped next cycle, no clear; ack asserted in that same cycle instead -> clear_o[5] pulses.
- Disabled core: core_en_i=0b1010, pending_i=0x3 -> offers go only to cores 1 and 3.
- Reset mid-offer: assert HRESET while 2 offers are active -> next cycle all outputs 0 and pointer 0; pending sources are reoffered starting from core0 after release.
